key_expansion_ctrl: RTL and testbench

KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

---
 rtl/key_expansion_ctrl.sv | 120 ++++++++++++
 tb/tb_key_expansion_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_ctrl.sv
// Sequences a cipher-key expansion through an external round-key generator,
// one request at a time, and keeps the resulting schedule in a readable key store.
module key_expansion_ctrl #(
  parameter int KEY_L = 128,
  parameter int WORD  = 32,
  parameter int NR    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_L-1:0] key_in,
  output logic             rkg_valid_in,
  output logic [KEY_L-1:0] rkg_key,
  output logic [WORD-1:0]  rkg_rcon,
  input  logic [KEY_L-1:0] rkg_round_key,
  input  logic             rkg_valid_out,
  input  logic [3:0]       rd_addr,
  output logic [KEY_L-1:0] rd_key,
  output logic             busy,
  output logic             done,
  output logic             keys_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t           state;
  state_t           state_next;
  logic [3:0]       round;
  logic [7:0]       rc;
  logic [KEY_L-1:0] key_q;
  logic [WORD-1:0]  rcon_q;
  logic [KEY_L-1:0] store [NR+1];
  logic             accept;
  logic             take;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Generator results are only accepted in WAIT, so stray or late strobes are dropped.
  always_comb begin
    state_next   = state;
    rkg_valid_in = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    take         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        rkg_valid_in = 1'b1;
        busy         = 1'b1;
        state_next   = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (rkg_valid_out) begin
          take       = 1'b1;
          state_next = (round == LAST) ? FINISH : ISSUE;
        end
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // key_q/rcon_q are loaded on the edge that enters ISSUE, so they stay frozen
  // for the whole outstanding request without a mux off the key store.
  always_ff @(posedge clk) begin
    if (reset) begin
      round      <= 4'd0;
      rc         <= 8'h01;
      key_q      <= '0;
      rcon_q     <= '0;
      keys_ready <= 1'b0;
      rd_key     <= '0;
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else begin
      if (accept) begin
        store[0]   <= key_in;
        round      <= 4'd1;
        rc         <= 8'h01;
        keys_ready <= 1'b0;
        key_q      <= key_in;
        rcon_q     <= {8'h01, {(WORD-8){1'b0}}};
      end
      if (take) begin
        store[round] <= rkg_round_key;
        key_q        <= rkg_round_key;
        if (round == LAST) begin
          keys_ready <= 1'b1;
        end else begin
          round  <= round + 4'd1;
          rc     <= xtime(rc);
          rcon_q <= {xtime(rc), {(WORD-8){1'b0}}};
        end
      end
      rd_key <= (rd_addr <= LAST) ? store[rd_addr] : '0;
    end
  end

  assign rkg_key  = key_q;
  assign rkg_rcon = rcon_q;

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench: AES-128 round-key generator model with random latency,
// plus a FIPS-197 word-wise key schedule model as the reference.
module tb_key_expansion_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key_in;
  logic         rkg_valid_in;
  logic [127:0] rkg_key;
  logic [31:0]  rkg_rcon;
  logic [127:0] rkg_round_key;
  logic         rkg_valid_out;
  logic [3:0]   rd_addr;
  logic [127:0] rd_key;
  logic         busy;
  logic         done;
  logic         keys_ready;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox [256];
  logic [127:0] exp_sched [11];
  logic [7:0]   exp_rc [10];

  int           gen_lat_min = 1;
  int           gen_lat_max = 1;
  int           pend = 0;
  logic [127:0] cap_key;
  logic [31:0]  cap_rcon;
  logic [127:0] gen_res;
  int           issue_cnt = 0;
  int           hold_errs = 0;
  int           done_cnt = 0;
  logic [31:0]  rcon_log [$];

  int           snap_done, snap_issue, snap_hold, snap_rcon;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_K10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  key_expansion_ctrl #(.KEY_L(128), .WORD(32), .NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .rkg_valid_in(rkg_valid_in), .rkg_key(rkg_key), .rkg_rcon(rkg_rcon),
    .rkg_round_key(rkg_round_key), .rkg_valid_out(rkg_valid_out),
    .rd_addr(rd_addr), .rd_key(rd_key), .busy(busy), .done(done),
    .keys_ready(keys_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One AES-128 round of the external generator: previous round key in, next out.
  function automatic logic [127:0] gen_round(input logic [127:0] prev, input logic [31:0] rcon);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = prev;
    t  = subword({w3[23:0], w3[31:24]}) ^ rcon;
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    int rc;
    rc = 1;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {8'(rc), 24'h0};
        exp_rc[i/4-1] = 8'(rc);
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11B;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) exp_sched[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] key);
    @(negedge clk);
    key_in = key;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic read_slot(input logic [3:0] a, output logic [127:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_key;
  endtask

  task automatic check_schedule(input string tag);
    logic [127:0] d;
    for (int i = 0; i < 11; i++) begin
      read_slot(4'(i), d);
      checkOutput($sformatf("%s_slot%0d", tag, i), d, exp_sched[i]);
    end
  endtask

  task automatic wait_issues(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (issue_cnt - snap_issue >= n) begin ok = 1'b1; break; end
    end
    checkOutput({tag, "_reach_issue"}, 128'(ok), 128'd1);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    int early;
    seen = 1'b0; early = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; break; end
      if (busy !== 1'b1) early++;
    end
    checkOutput({tag, "_done_seen"}, 128'(seen), 128'd1);
    checkOutput({tag, "_busy_early_drop"}, 128'(early), 128'd0);
    checkOutput({tag, "_ready_at_done"}, 128'(keys_ready), 128'd1);
    checkOutput({tag, "_busy_at_done"}, 128'(busy), 128'd0);
  endtask

  task automatic start_run(input string tag, input logic [127:0] key, input int lmin, input int lmax);
    snap_done = done_cnt; snap_issue = issue_cnt;
    snap_hold = hold_errs; snap_rcon = rcon_log.size();
    build_model(key);
    gen_lat_min = lmin; gen_lat_max = lmax;
    applyStimulus(key);
    checkOutput({tag, "_busy_after_start"}, 128'(busy), 128'd1);
  endtask

  task automatic finish_run(input string tag);
    wait_done(tag);
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_done_pulses"}, 128'(done_cnt - snap_done), 128'd1);
    checkOutput({tag, "_issue_pulses"}, 128'(issue_cnt - snap_issue), 128'd10);
    checkOutput({tag, "_hold_errors"}, 128'(hold_errs - snap_hold), 128'd0);
    for (int k = 0; k < 10; k++) begin
      if (snap_rcon + k < rcon_log.size())
        checkOutput($sformatf("%s_rcon%0d", tag, k), 128'(rcon_log[snap_rcon+k]), 128'({exp_rc[k], 24'h0}));
      else
        checkOutput($sformatf("%s_rcon%0d_missing", tag, k), 128'(rcon_log.size()), 128'(snap_rcon + k + 1));
    end
    check_schedule(tag);
  endtask

  // Generator model: captures each request, holds one result, returns it after a random latency.
  initial begin
    rkg_valid_out = 1'b0;
    rkg_round_key = '0;
    forever begin
      @(posedge clk);
      #1;
      rkg_valid_out = 1'b0;
      if (pend > 0) begin
        if (busy === 1'b1 && (rkg_key !== cap_key || rkg_rcon !== cap_rcon)) hold_errs++;
        pend--;
        if (pend == 0) begin
          rkg_valid_out = 1'b1;
          rkg_round_key = gen_res;
        end
      end
      if (rkg_valid_in === 1'b1) begin
        if (pend > 0) hold_errs++;
        issue_cnt++;
        rcon_log.push_back(rkg_rcon);
        cap_key  = rkg_key;
        cap_rcon = rkg_rcon;
        gen_res  = gen_round(rkg_key, rkg_rcon);
        pend     = int'($urandom_range(gen_lat_max, gen_lat_min));
      end
    end
  end

  initial begin
    logic [127:0] d;
    logic [127:0] rk;
    logic [7:0]   inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    reset = 1'b1; start = 1'b0; key_in = '0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rkg_valid_in", 128'(rkg_valid_in), 128'd0);
    checkOutput("reset_rkg_key", rkg_key, 128'd0);
    checkOutput("reset_rkg_rcon", 128'(rkg_rcon), 128'd0);
    checkOutput("reset_rd_key", rd_key, 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_done", 128'(done), 128'd0);
    checkOutput("reset_keys_ready", 128'(keys_ready), 128'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] known-answer expansion");
    start_run("fips", FIPS_KEY, 1, 4);
    finish_run("fips");
    read_slot(4'd1, d);
    checkOutput("fips_kat_slot1", d, FIPS_K1);
    read_slot(4'd10, d);
    checkOutput("fips_kat_slot10", d, FIPS_K10);

    $display("[TB] start during WAIT of round 3");
    start_run("ignore", FIPS_KEY, 9, 9);
    wait_issues(3, "ignore");
    @(negedge clk);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    finish_run("ignore");
    read_slot(4'd10, d);
    checkOutput("ignore_kat_slot10", d, FIPS_K10);

    $display("[TB] latency 1 vs latency 9");
    rk = {$urandom, $urandom, $urandom, $urandom};
    start_run("lat1", rk, 1, 1);
    finish_run("lat1");
    start_run("lat9", rk, 9, 9);
    finish_run("lat9");
    for (int a = 11; a < 16; a++) begin
      read_slot(4'(a), d);
      checkOutput($sformatf("oob_addr%0d", a), d, 128'd0);
    end

    for (int r = 0; r < 3; r++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      start_run($sformatf("rand%0d", r), rk, 1, 6);
      finish_run($sformatf("rand%0d", r));
    end

    $display("[TB] restart with keys_ready set");
    rd_addr = 4'd0;
    rk = exp_sched[0];
    @(negedge clk);
    start_run("restart", SEQ_KEY, 1, 3);
    checkOutput("restart_keys_ready_low", 128'(keys_ready), 128'd0);
    checkOutput("restart_read_old_slot0", rd_key, rk);
    @(negedge clk);
    checkOutput("restart_read_new_slot0", rd_key, SEQ_KEY);
    finish_run("restart");
    read_slot(4'd10, d);
    checkOutput("restart_kat_slot10", d, SEQ_K10);

    $display("[TB] reset during WAIT of round 5");
    start_run("abort", {$urandom, $urandom, $urandom, $urandom}, 9, 9);
    wait_issues(5, "abort");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_rst_valid_in", 128'(rkg_valid_in), 128'd0);
    checkOutput("abort_rst_rkg_key", rkg_key, 128'd0);
    checkOutput("abort_rst_busy", 128'(busy), 128'd0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("abort_issue_pulses", 128'(issue_cnt - snap_issue), 128'd5);
    checkOutput("abort_done_pulses", 128'(done_cnt - snap_done), 128'd0);
    checkOutput("abort_keys_ready", 128'(keys_ready), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    for (int i = 0; i < 11; i++) begin
      read_slot(4'(i), d);
      checkOutput($sformatf("abort_slot%0d", i), d, 128'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
